// File: rtl/insn_sequencer.sv
// Multicycle step sequencer for the RISC core: drives the decoder step counter,
// gates instruction fetch, supports run/halt/single-step, and traps hung instructions.
module insn_sequencer #(
    parameter int CNT_W   = 3,
    parameter int MAX_CNT = 7,
    parameter int RET_W   = 16
) (
    input  logic             clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic             Step_En,
    input  logic             Step,
    input  logic             Mem_Ack,
    input  logic             Buff_PC,
    input  logic             Done,
    output logic [CNT_W-1:0] Cnt,
    output logic             Mem_Req,
    output logic             Run,
    output logic             Halted,
    output logic             Fault,
    output logic [RET_W-1:0] Ret_Cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_PAUSE,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CNT);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mem_req_q;
    logic             run_q;
    logic             halted_q;
    logic             fault_q;
    logic [RET_W-1:0] ret_q;

    // Every output is a flop updated together with the state, so the
    // decoder never sees a combinational glitch on Cnt or Run.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mem_req_q <= 1'b0;
            run_q     <= 1'b0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
            ret_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop reading the pre-edge value of its peers.
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        state_q   <= S_FETCH;
                        mem_req_q <= 1'b1;
                        ret_q     <= '0;
                    end
                end

                S_FETCH: begin
                    if (Mem_Ack) begin
                        state_q   <= S_EXEC;
                        mem_req_q <= 1'b0;
                        run_q     <= 1'b1;
                        cnt_q     <= CNT_W'(1);
                    end
                end

                S_EXEC: begin
                    // A completing instruction wins over the watchdog on the last legal step.
                    if (Buff_PC) begin
                        ret_q <= ret_q + RET_W'(1);
                        cnt_q <= '0;
                        run_q <= 1'b0;
                        if (Done) begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                        end else if (Step_En) begin
                            state_q <= S_PAUSE;
                        end else begin
                            state_q   <= S_FETCH;
                            mem_req_q <= 1'b1;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= S_FAULT;
                        fault_q <= 1'b1;
                        run_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_PAUSE: begin
                    if (Step || !Step_En) begin
                        state_q   <= S_FETCH;
                        mem_req_q <= 1'b1;
                    end
                end

                S_HALT: begin
                    if (Start) begin
                        state_q   <= S_FETCH;
                        halted_q  <= 1'b0;
                        mem_req_q <= 1'b1;
                    end
                end

                S_FAULT: begin
                    state_q <= S_FAULT;
                end

                // NOTE: the two unused state codes fall back to a clean IDLE instead of locking up.
                default: begin
                    state_q   <= S_IDLE;
                    cnt_q     <= '0;
                    mem_req_q <= 1'b0;
                    run_q     <= 1'b0;
                    halted_q  <= 1'b0;
                    fault_q   <= 1'b0;
                end
            endcase
        end
    end

    assign Cnt     = cnt_q;
    assign Mem_Req = mem_req_q;
    assign Run     = run_q;
    assign Halted  = halted_q;
    assign Fault   = fault_q;
    assign Ret_Cnt = ret_q;

endmodule

// File: tb/tb_insn_sequencer.sv
// Self-checking bench for insn_sequencer: cycle-by-cycle vector table through a
// scoreboard queue, plus hand sequences for watchdog, async reset and counter wrap.
module tb_insn_sequencer;

    localparam int CNT_W   = 3;
    localparam int MAX_CNT = 7;
    localparam int RET_W   = 4;

    logic             clk = 1'b0;
    logic             Rst_n;
    logic             Start, Step_En, Step, Mem_Ack, Buff_PC, Done;
    logic [CNT_W-1:0] Cnt;
    logic             Mem_Req, Run, Halted, Fault;
    logic [RET_W-1:0] Ret_Cnt;

    int n_checks = 0;
    int n_errors = 0;

    insn_sequencer #(
        .CNT_W  (CNT_W),
        .MAX_CNT(MAX_CNT),
        .RET_W  (RET_W)
    ) dut (
        .clk    (clk),
        .Rst_n  (Rst_n),
        .Start  (Start),
        .Step_En(Step_En),
        .Step   (Step),
        .Mem_Ack(Mem_Ack),
        .Buff_PC(Buff_PC),
        .Done   (Done),
        .Cnt    (Cnt),
        .Mem_Req(Mem_Req),
        .Run    (Run),
        .Halted (Halted),
        .Fault  (Fault),
        .Ret_Cnt(Ret_Cnt)
    );

    always #5 clk = ~clk;

    // Inputs {Start,Step_En,Step,Mem_Ack,Buff_PC,Done}; expected flags {Mem_Req,Run,Halted,Fault}.
    typedef struct {
        logic [5:0] in;
        int         cnt;
        logic [3:0] flg;
        int         ret;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t mk(input logic [5:0] in, input int cnt, input logic [3:0] flg,
                                input int ret);
        vec_t v;
        v.in  = in;
        v.cnt = cnt;
        v.flg = flg;
        v.ret = ret;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] in);
        {Start, Step_En, Step, Mem_Ack, Buff_PC, Done} = in;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all(input string tag, input int cnt, input logic [3:0] flg, input int ret);
        check({tag, ".cnt"},     int'(Cnt),     cnt);
        check({tag, ".mem_req"}, int'(Mem_Req), int'(flg[3]));
        check({tag, ".run"},     int'(Run),     int'(flg[2]));
        check({tag, ".halted"},  int'(Halted),  int'(flg[1]));
        check({tag, ".fault"},   int'(Fault),   int'(flg[0]));
        check({tag, ".ret"},     int'(Ret_Cnt), ret);
    endtask

    // Drive one vector, queue its expectation, and compare after the clock edge.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        drive(v.in);
        exp_q.push_back(v);
        cycle();
        e = exp_q.pop_front();
        check_all(tag, e.cnt, e.flg, e.ret);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected $finish");
        $fatal(1);
    end

    initial begin
        int n;

        Rst_n = 1'b0;
        drive(6'b000000);
        repeat (2) @(negedge clk);
        check_all("reset", 0, 4'b0000, 0);
        Rst_n = 1'b1;

        // IDLE ignores everything but Start; Buff_PC at Cnt=3 repeatedly with Mem_Ack tied high.
        tbl.push_back(mk(6'b000000, 0, 4'b0000, 0));
        tbl.push_back(mk(6'b000110, 0, 4'b0000, 0));
        tbl.push_back(mk(6'b100000, 0, 4'b1000, 0));
        tbl.push_back(mk(6'b000100, 1, 4'b0100, 0));
        tbl.push_back(mk(6'b000100, 2, 4'b0100, 0));
        tbl.push_back(mk(6'b000100, 3, 4'b0100, 0));
        tbl.push_back(mk(6'b000110, 0, 4'b1000, 1));
        tbl.push_back(mk(6'b000100, 1, 4'b0100, 1));
        tbl.push_back(mk(6'b100100, 2, 4'b0100, 1));
        tbl.push_back(mk(6'b000100, 3, 4'b0100, 1));
        tbl.push_back(mk(6'b000110, 0, 4'b1000, 2));
        // Memory wait: five cycles without Mem_Ack.
        for (int i = 0; i < 5; i++) tbl.push_back(mk(6'b000000, 0, 4'b1000, 2));
        tbl.push_back(mk(6'b000100, 1, 4'b0100, 2));
        // Done alone is ignored, then HLT at Cnt=2, then restart from HALT.
        tbl.push_back(mk(6'b000001, 2, 4'b0100, 2));
        tbl.push_back(mk(6'b000011, 0, 4'b0010, 3));
        tbl.push_back(mk(6'b011110, 0, 4'b0010, 3));
        tbl.push_back(mk(6'b100000, 0, 4'b1000, 3));
        tbl.push_back(mk(6'b000100, 1, 4'b0100, 3));
        tbl.push_back(mk(6'b000010, 0, 4'b1000, 4));
        // Single-step: Step coinciding with EXEC->PAUSE is dropped; three pulses retire three.
        tbl.push_back(mk(6'b010100, 1, 4'b0100, 4));
        tbl.push_back(mk(6'b011010, 0, 4'b0000, 5));
        tbl.push_back(mk(6'b010000, 0, 4'b0000, 5));
        tbl.push_back(mk(6'b011000, 0, 4'b1000, 5));
        tbl.push_back(mk(6'b011100, 1, 4'b0100, 5));
        tbl.push_back(mk(6'b011000, 2, 4'b0100, 5));
        tbl.push_back(mk(6'b010010, 0, 4'b0000, 6));
        tbl.push_back(mk(6'b011000, 0, 4'b1000, 6));
        tbl.push_back(mk(6'b010100, 1, 4'b0100, 6));
        tbl.push_back(mk(6'b010010, 0, 4'b0000, 7));
        tbl.push_back(mk(6'b011000, 0, 4'b1000, 7));
        tbl.push_back(mk(6'b010100, 1, 4'b0100, 7));
        tbl.push_back(mk(6'b010010, 0, 4'b0000, 8));
        tbl.push_back(mk(6'b010000, 0, 4'b0000, 8));
        tbl.push_back(mk(6'b000000, 0, 4'b1000, 8));
        // Buff_PC exactly at Cnt=MAX_CNT completes without a fault.
        tbl.push_back(mk(6'b000100, 1, 4'b0100, 8));
        for (int c = 2; c <= MAX_CNT; c++) tbl.push_back(mk(6'b000000, c, 4'b0100, 8));
        tbl.push_back(mk(6'b000010, 0, 4'b1000, 9));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Watchdog: Buff_PC never arrives.
        drive(6'b000100);
        cycle();
        check("wd_enter.cnt", int'(Cnt), 1);
        drive(6'b000000);
        n = 0;
        while (!Fault && n < 20) begin
            cycle();
            n++;
        end
        check("wd_latency", n, MAX_CNT);
        check_all("wd_fault", MAX_CNT, 4'b0001, 9);
        drive(6'b111111);
        repeat (2) cycle();
        check_all("wd_sticky", MAX_CNT, 4'b0001, 9);

        // Reset is the only exit from FAULT.
        drive(6'b000000);
        #2 Rst_n = 1'b0;
        #1 check_all("fault_reset", 0, 4'b0000, 0);
        @(negedge clk);
        Rst_n = 1'b1;

        // Asynchronous reset mid-EXEC at Cnt=2 with one retirement on record.
        drive(6'b100000); cycle();
        drive(6'b000100); cycle();
        drive(6'b000010); cycle();
        drive(6'b000100); cycle();
        drive(6'b000000); cycle();
        check_all("pre_reset", 2, 4'b0100, 1);
        #2 Rst_n = 1'b0;
        #1 check_all("async_reset", 0, 4'b0000, 0);
        @(negedge clk);
        Rst_n = 1'b1;
        drive(6'b000110);
        cycle();
        check_all("post_reset_idle", 0, 4'b0000, 0);

        // Retired counter wraps from all-ones to zero.
        apply(mk(6'b100000, 0, 4'b1000, 0), "wrap_start");
        for (int i = 0; i < (1 << RET_W); i++) begin
            apply(mk(6'b000100, 1, 4'b0100, i), $sformatf("wrap_exec%0d", i));
            apply(mk(6'b000010, 0, 4'b1000, (i + 1) % (1 << RET_W)), $sformatf("wrap_ret%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
